pipeline_hazard_controller: RTL and testbench

Sequences the four-stage pipeline (IF, ID, EX/MEM, WB) by driving the PC write-enable and the pipeline-buffer stall, flush and bubble controls. It detects RAW data hazards between the ID instruction and the instructions in EX/MEM and WB. It squashes wrong-path fetches on taken jumps and branches, and runs a small FSM that holds fetch while a JM instruction travels to WB. There is no forwarding in the datapath, so this block alone guarantees correct operand reads.

---
 rtl/cpu_isa_pkg.sv | 46 ++++
 rtl/hazard_compare.sv | 38 +++
 rtl/pipeline_hazard_controller.sv | 156 +++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the pipeline hazard controller: opcode
// encodings, register address width, the controller FSM state type and
// the per-opcode source-operand usage decoders.
package cpu_isa_pkg;

  localparam int REG_W = 6;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_INC  = 4'b0101;
  localparam logic [3:0] OP_NEG  = 4'b0110;
  localparam logic [3:0] OP_SUB  = 4'b0111;
  localparam logic [3:0] OP_J    = 4'b1000;
  localparam logic [3:0] OP_BRZ  = 4'b1001;
  localparam logic [3:0] OP_JM   = 4'b1010;
  localparam logic [3:0] OP_BRN  = 4'b1011;
  localparam logic [3:0] OP_LD   = 4'b1110;
  localparam logic [3:0] OP_SVPC = 4'b1111;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DSTALL = 2'd1,
    JM_EX  = 2'd2,
    JM_WB  = 2'd3
  } hz_state_t;

  // Opcodes that read the rs1 field; unlisted encodings read nothing.
  function automatic logic uses_rs1(input logic [3:0] opcode);
    case (opcode)
      OP_ADD, OP_SUB, OP_ST,
      OP_INC, OP_NEG, OP_LD,
      OP_J, OP_BRZ, OP_BRN, OP_JM: return 1'b1;
      default:                     return 1'b0;
    endcase
  endfunction

  // Opcodes that also read the rs2 field.
  function automatic logic uses_rs2(input logic [3:0] opcode);
    case (opcode)
      OP_ADD, OP_SUB, OP_ST: return 1'b1;
      default:               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/hazard_compare.sv
// RAW hazard detector: compares the decode-stage source registers that
// the opcode actually reads against the destinations of the instructions
// in EX/MEM and (when the register file cannot bypass) WB.
module hazard_compare
  import cpu_isa_pkg::*;
#(
  parameter int WB_BYPASS = 1
) (
  input  logic [3:0]       i_opcode,
  input  logic [REG_W-1:0] i_rs1,
  input  logic [REG_W-1:0] i_rs2,
  input  logic [REG_W-1:0] i_ex_rd,
  input  logic             i_ex_regwrite,
  input  logic [REG_W-1:0] i_wb_rd,
  input  logic             i_wb_regwrite,
  output logic             o_hazard
);

  // A WB producer only matters when the register file reads before it writes.
  localparam logic WB_CMP = (WB_BYPASS == 0);

  logic w_use1;
  logic w_use2;
  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_use1 = uses_rs1(i_opcode);
  assign w_use2 = uses_rs2(i_opcode);

  // Every register address participates; there is no hardwired zero.
  assign w_rs1_hit = (i_ex_regwrite && (i_rs1 == i_ex_rd)) ||
                     (WB_CMP && i_wb_regwrite && (i_rs1 == i_wb_rd));
  assign w_rs2_hit = (i_ex_regwrite && (i_rs2 == i_ex_rd)) ||
                     (WB_CMP && i_wb_regwrite && (i_rs2 == i_wb_rd));

  assign o_hazard = (w_use1 && w_rs1_hit) || (w_use2 && w_rs2_hit);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller for the four-stage IF/ID/EX-MEM/WB pipeline.
// Drives PC load, IF/ID load/flush and ID/EX bubble: stalls on RAW
// hazards, squashes wrong-path fetches on taken redirects and holds fetch
// while a JM travels to WB. Only the FSM state is registered; all controls
// are combinational from state and inputs.
// Optional build macro HAZARD_PERF_CNT_EN adds saturating stall/flush
// event counters (stall_cnt, flush_cnt).
module pipeline_hazard_controller
  import cpu_isa_pkg::*;
#(
  parameter int WB_BYPASS = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       id_opcode,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_regWrite,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_regWrite,
  input  logic             ex_redirect,
  input  logic             wb_jumpMem,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             jm_select,
`ifdef HAZARD_PERF_CNT_EN
  output logic [15:0]      stall_cnt,
  output logic [15:0]      flush_cnt,
`endif
  output logic [1:0]       state
);

  hz_state_t r_state;
  hz_state_t w_next;
  logic      w_hazard;

  hazard_compare #(
    .WB_BYPASS(WB_BYPASS)
  ) u_hazard_compare (
    .i_opcode      (id_opcode),
    .i_rs1         (id_rs1),
    .i_rs2         (id_rs2),
    .i_ex_rd       (ex_rd),
    .i_ex_regwrite (ex_regWrite),
    .i_wb_rd       (wb_rd),
    .i_wb_regwrite (wb_regWrite),
    .o_hazard      (w_hazard)
  );

  // State register; reset returns to RUN immediately, even mid-JM.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and pipeline controls; redirect outranks hazard outranks JM.
  always_comb begin
    w_next      = r_state;
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    jm_select   = 1'b0;
    case (r_state)
      RUN, DSTALL: begin
        if (ex_redirect) begin
          // Taken J/branch: the fetch behind it is wrong-path, squash it.
          pc_write    = 1'b1;
          ifid_write  = 1'b1;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          w_next      = RUN;
        end else if (w_hazard) begin
          // Freeze PC and IF/ID, send a bubble until the producer retires.
          idex_bubble = 1'b1;
          w_next      = DSTALL;
        end else if (id_opcode == OP_JM) begin
          // JM advances; fetch is held and flushed until its target is known.
          ifid_write  = 1'b1;
          ifid_flush  = 1'b1;
          w_next      = JM_EX;
        end else begin
          pc_write    = 1'b1;
          ifid_write  = 1'b1;
          w_next      = RUN;
        end
      end
      JM_EX: begin
        // JM owns the PC; a redirect from the squashed slot is meaningless.
        ifid_write  = 1'b1;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        w_next      = JM_WB;
      end
      JM_WB: begin
        // Without wb_jumpMem the target is untrusted: fall through on the PC path.
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        jm_select   = wb_jumpMem;
        w_next      = RUN;
      end
      default: begin
        w_next = RUN;
      end
    endcase
    if (reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      jm_select   = 1'b0;
      w_next      = RUN;
    end
  end

  assign state = r_state;

`ifdef HAZARD_PERF_CNT_EN
  logic w_stall_evt;
  logic w_flush_evt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign w_stall_evt = !reset && ((r_state == RUN) || (r_state == DSTALL)) &&
                       !ex_redirect && w_hazard;
  assign w_flush_evt = !reset && ifid_flush;

  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  // Saturating event counters for stall cycles and IF/ID flush cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= 16'd0;
      r_flush_cnt <= 16'd0;
    end else begin
      if (w_stall_evt) r_stall_cnt <= sat_inc(r_stall_cnt);
      if (w_flush_evt) r_flush_cnt <= sat_inc(r_flush_cnt);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench: two controllers (WB_BYPASS = 0 and 1) share one
// stimulus stream; directed scenarios are followed by random traffic and
// every cycle is compared with a behavioural pipeline-control model.
module tb_pipeline_hazard_controller;

  localparam logic [3:0] NOP = 4'b0000, ST = 4'b0011, ADD = 4'b0100, INC = 4'b0101;
  localparam logic [3:0] NEG = 4'b0110, SUB = 4'b0111, J = 4'b1000, BRZ = 4'b1001;
  localparam logic [3:0] JM = 4'b1010, BRN = 4'b1011, LD = 4'b1110, SVPC = 4'b1111;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] id_opcode = '0;
  logic [5:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0, wb_rd = '0;
  logic       ex_regWrite = 1'b0, wb_regWrite = 1'b0, ex_redirect = 1'b0, wb_jumpMem = 1'b0;

  logic       pc_w [2], ifid_w [2], flush [2], bubble [2], jmsel [2];
  logic [1:0] st [2];
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] scnt [2], fcnt [2];
  int          m_scnt [2], m_fcnt [2];
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Model state: jm_phase 0 = no JM in flight, 1 = JM in EX/MEM, 2 = JM in WB.
  int   m_jm [2];
  logic m_stalled [2];

  always #5 clock = ~clock;

  pipeline_hazard_controller #(.WB_BYPASS(0)) dut0 (
    .clock(clock), .reset(reset), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_rd(ex_rd), .ex_regWrite(ex_regWrite), .wb_rd(wb_rd), .wb_regWrite(wb_regWrite),
    .ex_redirect(ex_redirect), .wb_jumpMem(wb_jumpMem),
    .pc_write(pc_w[0]), .ifid_write(ifid_w[0]), .ifid_flush(flush[0]),
    .idex_bubble(bubble[0]), .jm_select(jmsel[0]),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cnt(scnt[0]), .flush_cnt(fcnt[0]),
`endif
    .state(st[0]));

  pipeline_hazard_controller #(.WB_BYPASS(1)) dut1 (
    .clock(clock), .reset(reset), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_rd(ex_rd), .ex_regWrite(ex_regWrite), .wb_rd(wb_rd), .wb_regWrite(wb_regWrite),
    .ex_redirect(ex_redirect), .wb_jumpMem(wb_jumpMem),
    .pc_write(pc_w[1]), .ifid_write(ifid_w[1]), .ifid_flush(flush[1]),
    .idex_bubble(bubble[1]), .jm_select(jmsel[1]),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cnt(scnt[1]), .flush_cnt(fcnt[1]),
`endif
    .state(st[1]));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Number of register sources the opcode reads.
  function automatic int nsrc(input logic [3:0] op);
    if (op == ADD || op == SUB || op == ST) return 2;
    if (op == INC || op == NEG || op == LD || op == J || op == BRZ || op == BRN || op == JM) return 1;
    return 0;
  endfunction

  function automatic logic produced(input int b, input logic [5:0] r);
    return (ex_regWrite && r == ex_rd) || (b == 0 && wb_regWrite && r == wb_rd);
  endfunction

  function automatic logic raw(input int b);
    int n = nsrc(id_opcode);
    return (n >= 1 && produced(b, id_rs1)) || (n == 2 && produced(b, id_rs2));
  endfunction

  // Expected controls {pc_write, ifid_write, ifid_flush, idex_bubble, jm_select}.
  task automatic model(input int b, output logic [4:0] o, output logic [1:0] est,
                       output logic nstall, output int njm, output logic stall_evt);
    est       = (m_jm[b] == 1) ? 2'd2 : (m_jm[b] == 2) ? 2'd3 : (m_stalled[b] ? 2'd1 : 2'd0);
    nstall    = 1'b0;
    njm       = 0;
    stall_evt = 1'b0;
    if (m_jm[b] == 1) begin
      o = 5'b01110; njm = 2;
    end else if (m_jm[b] == 2) begin
      o = {4'b1111, wb_jumpMem};
    end else if (ex_redirect) begin
      o = 5'b11110;
    end else if (raw(b)) begin
      o = 5'b00010; nstall = 1'b1; stall_evt = 1'b1;
    end else if (id_opcode == JM) begin
      o = 5'b01100; njm = 1;
    end else begin
      o = 5'b11000;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int b = 0; b < 2; b++) begin
      chk($sformatf("%s_state%0d", tag, b), 16'(st[b]), 16'd0);
      chk($sformatf("%s_ctl%0d", tag, b),
          16'({pc_w[b], ifid_w[b], flush[b], bubble[b], jmsel[b]}), 16'b01110);
`ifdef HAZARD_PERF_CNT_EN
      chk($sformatf("%s_scnt%0d", tag, b), scnt[b], 16'd0);
      chk($sformatf("%s_fcnt%0d", tag, b), fcnt[b], 16'd0);
      m_scnt[b] = 0; m_fcnt[b] = 0;
`endif
      m_jm[b] = 0; m_stalled[b] = 1'b0;
    end
  endtask

  // One pipeline cycle: drive just after the edge, check mid-cycle, commit model at the edge.
  task automatic cyc(input logic [3:0] op, input logic [5:0] r1, input logic [5:0] r2,
                     input logic [5:0] erd, input logic ew, input logic [5:0] wrd,
                     input logic ww, input logic red, input logic wjm, input logic rst_mid);
    logic [4:0] o [2];
    logic [1:0] est;
    logic       nst [2];
    logic       sev;
    int         njm [2];
    id_opcode = op; id_rs1 = r1; id_rs2 = r2; ex_rd = erd; ex_regWrite = ew;
    wb_rd = wrd; wb_regWrite = ww; ex_redirect = red; wb_jumpMem = wjm;
    if (rst_mid) begin
      #1 reset = 1'b1;
      #2 check_reset_outputs("rst_mid");
      #1 reset = 1'b0;
      #1;
    end else begin
      #5;
    end
    for (int b = 0; b < 2; b++) begin
      model(b, o[b], est, nst[b], njm[b], sev);
      chk($sformatf("state%0d", b), 16'(st[b]), 16'(est));
      chk($sformatf("ctl%0d", b), 16'({pc_w[b], ifid_w[b], flush[b], bubble[b], jmsel[b]}), 16'(o[b]));
`ifdef HAZARD_PERF_CNT_EN
      chk($sformatf("scnt%0d", b), scnt[b], 16'(m_scnt[b]));
      chk($sformatf("fcnt%0d", b), fcnt[b], 16'(m_fcnt[b]));
      if (sev && m_scnt[b] < 65535) m_scnt[b]++;
      if (o[b][2] && m_fcnt[b] < 65535) m_fcnt[b]++;
`endif
    end
    @(posedge clock);
    for (int b = 0; b < 2; b++) begin
      m_stalled[b] = nst[b];
      m_jm[b]      = njm[b];
    end
    #1;
  endtask

  initial begin
    logic [5:0] rr [5];
    for (int b = 0; b < 2; b++) begin
      m_jm[b] = 0; m_stalled[b] = 1'b0;
`ifdef HAZARD_PERF_CNT_EN
      m_scnt[b] = 0; m_fcnt[b] = 0;
`endif
    end
    repeat (2) @(posedge clock);
    #3 check_reset_outputs("reset");
    #1 reset = 1'b0;
    @(posedge clock); #1;

    // Data stall: SUB reads r3 while ADD r3 sits in EX/MEM, then it moves to WB.
    cyc(SUB, 6'd1, 6'd3, 6'd3, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(SUB, 6'd1, 6'd3, 6'd0, 1'b0, 6'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(SUB, 6'd1, 6'd3, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    // No false stall: INC ignores rs2; SVPC reads nothing.
    cyc(INC, 6'd5, 6'd3, 6'd3, 1'b1, 6'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(SVPC, 6'd3, 6'd3, 6'd3, 1'b1, 6'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    // Redirect wins over a pending hazard.
    cyc(ADD, 6'd3, 6'd3, 6'd3, 1'b1, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    // JM sequence with a valid WB target.
    cyc(JM, 6'd9, 6'd0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(NOP, 6'd0, 6'd0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(NOP, 6'd0, 6'd0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(NOP, 6'd0, 6'd0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    // JM whose WB lacks wb_jumpMem.
    cyc(JM, 6'd9, 6'd0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(NOP, 6'd0, 6'd0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(NOP, 6'd0, 6'd0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Reset mid-JM, then a NOP fetches normally.
    cyc(JM, 6'd9, 6'd0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(NOP, 6'd0, 6'd0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(NOP, 6'd0, 6'd0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    // WB producer: stalls only the non-bypassing build.
    cyc(LD, 6'd7, 6'd0, 6'd0, 1'b0, 6'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(LD, 6'd7, 6'd0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Address 63 and 0 are ordinary registers.
    cyc(ST, 6'd0, 6'd63, 6'd63, 1'b1, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 2000; i++) begin
      for (int k = 0; k < 5; k++)
        rr[k] = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 3));
      cyc(4'($urandom_range(0, 15)), rr[0], rr[1], rr[2], 1'($urandom_range(0, 1)),
          rr[3], 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 4) != 0), ($urandom_range(0, 99) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
